// File: rtl/core_mem_arb.sv
// Two-master round-robin arbiter: instruction (i_*) and data (d_*) ports share one memory
// port (m_*). One transaction in flight; a watchdog turns a stalled memory access into an
// error response. Every output is driven straight from a register.
module core_mem_arb #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // instruction master
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  // data master
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  // memory slave
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata
);

  localparam int unsigned BW = DW / 8;
  // Keep the timer at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TimerMax  = TW'(TIMEOUT);
  localparam bit WatchdogOn = (TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;   // 1: last grant went to the data port
  logic [TW-1:0]   timer_q, timer_d;

  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [BW-1:0]   m_be_q, m_be_d;

  logic            i_ack_q, i_ack_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic            i_err_q, i_err_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            d_err_q, d_err_d;

  logic            sel_data;
  logic            timeout_hit;
  logic            resp_err;
  logic [DW-1:0]   resp_data;

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    timer_d   = timer_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    i_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    i_err_d   = i_err_q;
    d_ack_d   = 1'b0;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    // Tie goes to whichever master was not served last.
    sel_data    = d_req && (!i_req || !last_d_q);
    timeout_hit = WatchdogOn && (timer_q == TimerLast);
    resp_err    = !m_ack;
    resp_data   = m_ack ? m_rdata : '0;

    case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          state_d   = StBusy;
          last_d_d  = sel_data;
          timer_d   = '0;
          m_req_d   = 1'b1;
          m_we_d    = sel_data ? d_we : 1'b0;
          m_addr_d  = sel_data ? d_addr : i_addr;
          m_wdata_d = sel_data ? d_wdata : '0;
          m_be_d    = sel_data ? d_be : '1;
        end
      end
      StBusy: begin
        if (timer_q != TimerMax) begin
          timer_d = timer_q + TW'(1);
        end
        // m_ack takes priority over a coincident timeout.
        if (m_ack || timeout_hit) begin
          state_d = StResp;
          m_req_d = 1'b0;
          if (last_d_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data;
            d_err_d   = resp_err;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data;
            i_err_d   = resp_err;
          end
        end
      end
      StResp: begin
        // Ack is visible this cycle; no grant so a still-high old request is not reissued.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b1;
      timer_q   <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      timer_q   <= timer_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      i_ack_q   <= i_ack_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_ack_q   <= d_ack_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule
